mc_control_fsm: RTL

Multi-cycle MIPS control unit that replaces the single-cycle combinational decoder. It sequences each instruction through the FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and stalls on a memory ready handshake. It drives every datapath mux, enable and ALU control line, and it counts retired instructions. It sits between the instruction register and the shared-memory multi-cycle datapath.

---
 rtl/mc_control_fsm.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS control unit with memory-ready stalls and retire counter
// Optional macro JUMP_EN: decodes J (opcode 000010) into a dedicated JUMP state.
module mc_control_fsm #(
  parameter int ALUC_W = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        opcode,
  input  logic [5:0]        func,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dest,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic              imm_zext,
  output logic [1:0]        pc_source,
  output logic [ALUC_W-1:0] aluc,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  retired,
  output logic [3:0]        state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  state_t           state;
  state_t           state_nx;
  state_t           dec_nx;
  logic             dec_illegal;
  logic             func_ok;
  logic [2:0]       func_alu;
  logic [5:0]       op_q;
  logic [5:0]       func_q;
  logic [CNT_W-1:0] cnt;
  logic             retire;

  // The zero flag only qualifies pc_write_cond inside the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b000000: rtype_alu = ALU_SLL;
      6'b000010: rtype_alu = ALU_SRL;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   rtype_alu = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    func_ok = 1'b0;
    case (func)
      6'b100000, 6'b100010, 6'b000000, 6'b000010,
      6'b100100, 6'b100101, 6'b101010: func_ok = 1'b1;
      default:                         func_ok = 1'b0;
    endcase
  end

  assign func_alu = rtype_alu(func_q);

  // DECODE dispatch works on the live IR fields; later states use the latched copy.
  always_comb begin
    dec_nx      = S_FETCH;
    dec_illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (func_ok) dec_nx = S_EXEC;
        else         dec_illegal = 1'b1;
      end
      OP_LW, OP_SW, OP_LH:       dec_nx = S_MEMADR;
      OP_BEQ:                    dec_nx = S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI:  dec_nx = S_IMMEX;
`ifdef JUMP_EN
      OP_J:                      dec_nx = S_JUMP;
`endif
      default:                   dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:  state_nx = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_nx = dec_nx;
      S_MEMADR: state_nx = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_nx = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_nx = S_FETCH;
      S_MEMWR:  state_nx = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nx = S_ALUWB;
      S_ALUWB:  state_nx = S_FETCH;
      S_BRANCH: state_nx = S_FETCH;
      S_IMMEX:  state_nx = S_IMMWB;
      S_IMMWB:  state_nx = S_FETCH;
      S_JUMP:   state_nx = S_FETCH;
      default:  state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state)
      S_ALUWB, S_MEMWB, S_BRANCH, S_IMMWB, S_JUMP: retire = 1'b1;
      S_MEMWR:                                     retire = mem_ready;
      default:                                     retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      op_q   <= 6'd0;
      func_q <= 6'd0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) begin
        op_q   <= opcode;
        func_q <= func;
      end
      if (retire) cnt <= cnt + 1'b1;
    end
  end

  logic       c_pc_write, c_pc_write_cond, c_iord, c_mem_read, c_mem_write;
  logic       c_ir_write, c_reg_dest, c_mem_to_reg, c_reg_write, c_alu_src_a;
  logic [1:0] c_alu_src_b, c_pc_source;
  logic       c_imm_zext, c_illegal;
  logic [2:0] c_aluc;

  always_comb begin
    c_pc_write      = 1'b0;
    c_pc_write_cond = 1'b0;
    c_iord          = 1'b0;
    c_mem_read      = 1'b0;
    c_mem_write     = 1'b0;
    c_ir_write      = 1'b0;
    c_reg_dest      = 1'b0;
    c_mem_to_reg    = 1'b0;
    c_reg_write     = 1'b0;
    c_alu_src_a     = 1'b0;
    c_alu_src_b     = 2'b00;
    c_imm_zext      = 1'b0;
    c_pc_source     = 2'b00;
    c_aluc          = ALU_ADD;
    c_illegal       = 1'b0;
    case (state)
      S_FETCH: begin
        c_mem_read  = 1'b1;
        c_alu_src_b = 2'b01;
        c_ir_write  = mem_ready;
        c_pc_write  = mem_ready;
      end
      S_DECODE: begin
        c_alu_src_b = 2'b11;
        c_illegal   = dec_illegal;
      end
      S_MEMADR: begin
        c_alu_src_a = 1'b1;
        c_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c_mem_read = 1'b1;
        c_iord     = 1'b1;
      end
      S_MEMWB: begin
        c_mem_to_reg = 1'b1;
        c_reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c_mem_write = 1'b1;
        c_iord      = 1'b1;
      end
      S_EXEC: begin
        c_alu_src_a = 1'b1;
        c_aluc      = func_alu;
      end
      S_ALUWB: begin
        c_reg_dest  = 1'b1;
        c_reg_write = 1'b1;
      end
      S_BRANCH: begin
        c_alu_src_a     = 1'b1;
        c_aluc          = ALU_SUB;
        c_pc_write_cond = 1'b1;
        c_pc_source     = 2'b01;
      end
      S_IMMEX: begin
        c_alu_src_a = 1'b1;
        c_alu_src_b = 2'b10;
        if (op_q == OP_ANDI) begin
          c_aluc     = ALU_AND;
          c_imm_zext = 1'b1;
        end else if (op_q == OP_ORI) begin
          c_aluc     = ALU_OR;
          c_imm_zext = 1'b1;
        end
      end
      S_IMMWB: c_reg_write = 1'b1;
      S_JUMP: begin
        c_pc_write  = 1'b1;
        c_pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  // Reset gates every control line so nothing reaches the datapath while rst_n is low.
  assign pc_write      = rst_n & c_pc_write;
  assign pc_write_cond = rst_n & c_pc_write_cond;
  assign iord          = rst_n & c_iord;
  assign mem_read      = rst_n & c_mem_read;
  assign mem_write     = rst_n & c_mem_write;
  assign ir_write      = rst_n & c_ir_write;
  assign reg_dest      = rst_n & c_reg_dest;
  assign mem_to_reg    = rst_n & c_mem_to_reg;
  assign reg_write     = rst_n & c_reg_write;
  assign alu_src_a     = rst_n & c_alu_src_a;
  assign alu_src_b     = rst_n ? c_alu_src_b : 2'b00;
  assign imm_zext      = rst_n & c_imm_zext;
  assign pc_source     = rst_n ? c_pc_source : 2'b00;
  assign aluc          = rst_n ? ALUC_W'(c_aluc) : '0;
  assign illegal_op    = rst_n & c_illegal;
  assign retired       = cnt;
  assign state_o       = state;

endmodule
